// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: three per-pipe result FIFOs feeding the single PRF write port
// through a round-robin grant, with the issued write mirrored onto the RS wakeup bus.
module wb_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [PREG_W-1:0] alu_pd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              b_valid,
  input  logic [PREG_W-1:0] b_pd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              mem_valid,
  input  logic [PREG_W-1:0] mem_pd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              prf_write_en,
  output logic [PREG_W-1:0] prf_pd,
  output logic [DATA_W-1:0] prf_data,
  output logic              wakeup_valid,
  output logic [PREG_W-1:0] wakeup_pd,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_B   = 2'd1,
    SRC_MEM = 2'd2
  } src_e;

  logic [PREG_W-1:0] in_pd   [3];
  logic [DATA_W-1:0] in_data [3];
  logic [2:0]        in_valid;

  logic [PREG_W-1:0] fifo_pd   [3][DEPTH];
  logic [DATA_W-1:0] fifo_data [3][DEPTH];
  logic [PTR_W-1:0]  rd_ptr [3];
  logic [PTR_W-1:0]  wr_ptr [3];
  logic [PTR_W:0]    count  [3];

  logic [2:0]        ready;
  logic [2:0]        nonempty;
  logic [2:0]        push;
  logic [2:0]        pop;

  src_e              rr_last;
  src_e              grant_src;
  logic              grant_valid;
  src_e              order [3];
  logic [PREG_W-1:0] head_pd;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    in_valid   = {mem_valid, b_valid, alu_valid};
    in_pd[0]   = alu_pd;
    in_pd[1]   = b_pd;
    in_pd[2]   = mem_pd;
    in_data[0] = alu_data;
    in_data[1] = b_data;
    in_data[2] = mem_data;
  end

  // Ready is a function of registered occupancy only, so a full FIFO never accepts
  // even in a cycle where it is also being popped.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int s = 0; s < 3; s++) begin
      ready[s]    = (count[s] != (PTR_W+1)'(DEPTH));
      nonempty[s] = (count[s] != '0);
      push[s]     = in_valid[s] && ready[s];
    end
  end

  assign alu_ready = ready[0];
  assign b_ready   = ready[1];
  assign mem_ready = ready[2];
  assign busy      = |nonempty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        count[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (pop[s])  rd_ptr[s] <= rd_ptr[s] + 1'b1;
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + 1'b1;
          2'b01:   count[s] <= count[s] - 1'b1;
          default: count[s] <= count[s];
        endcase
      end
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (push[s]) begin
        fifo_pd[s][wr_ptr[s]]   <= in_pd[s];
        fifo_data[s][wr_ptr[s]] <= in_data[s];
      end
    end
  end

  // Search starts at the source after the last one granted.
  always_comb begin
    case (rr_last)
      SRC_ALU: begin order[0] = SRC_B;   order[1] = SRC_MEM; order[2] = SRC_ALU; end
      SRC_B:   begin order[0] = SRC_MEM; order[1] = SRC_ALU; order[2] = SRC_B;   end
      default: begin order[0] = SRC_ALU; order[1] = SRC_B;   order[2] = SRC_MEM; end
    endcase
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_src   = rr_last;
    pop         = '0;
    if (nonempty[order[0]]) begin
      grant_valid = 1'b1;
      grant_src   = order[0];
    end else if (nonempty[order[1]]) begin
      grant_valid = 1'b1;
      grant_src   = order[1];
    end else if (nonempty[order[2]]) begin
      grant_valid = 1'b1;
      grant_src   = order[2];
    end
    if (grant_valid) pop[grant_src] = 1'b1;
    head_pd   = fifo_pd[grant_src][rd_ptr[grant_src]];
    head_data = fifo_data[grant_src][rd_ptr[grant_src]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_last <= SRC_MEM;
    else if (grant_valid) rr_last <= grant_src;
  end

  // A grant for p0 still pops and uses its turn, but p0 is hardwired zero so no write issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prf_write_en <= 1'b0;
      prf_pd       <= '0;
      prf_data     <= '0;
    end else begin
      prf_write_en <= grant_valid && (head_pd != '0);
      if (grant_valid && (head_pd != '0)) begin
        prf_pd   <= head_pd;
        prf_data <= head_data;
      end
    end
  end

  assign wakeup_valid = prf_write_en;
  assign wakeup_pd    = prf_pd;

endmodule
